// File: rtl/hazard_scoreboard_if.sv
// Handshake bundle between the ID stage and the hazard scoreboard.
// master drives the ID-stage request fields; slave is the scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 3
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic                  forward_EN;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] src1_ID;
  logic [REG_ADDR_W-1:0] src2_ID;
  logic                  src1_used;
  logic                  src2_used;
  logic                  is_branch_ID;
  logic [REG_ADDR_W-1:0] dest_ID;
  logic                  wb_en_ID;
  logic                  mem_r_en_ID;
  logic                  mem_busy;
  logic                  flush;
  logic                  hazard_detected;
  logic [SEL_W-1:0]      fwd_sel1;
  logic [SEL_W-1:0]      fwd_sel2;
  logic [15:0]           stall_count;

  modport master (
    output forward_EN, id_valid, src1_ID, src2_ID, src1_used, src2_used,
           is_branch_ID, dest_ID, wb_en_ID, mem_r_en_ID, mem_busy, flush,
    input  hazard_detected, fwd_sel1, fwd_sel2, stall_count
  );

  modport slave (
    input  forward_EN, id_valid, src1_ID, src2_ID, src1_used, src2_used,
           is_branch_ID, dest_ID, wb_en_ID, mem_r_en_ID, mem_busy, flush,
    output hazard_detected, fwd_sel1, fwd_sel2, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: tracks in-flight writers after ID and decides
// stall vs. forward-source selection for the two ID source operands.
module hazard_scoreboard #(
  parameter int REG_ADDR_W   = 4,
  parameter int DEPTH        = 3,
  parameter int LOAD_FWD_IDX = 1,
  parameter bit ZERO_REG_HW  = 1'b1
) (
  input logic           clk,
  input logic           rst,
  hazard_scoreboard_if.slave sb
);
  localparam int SEL_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]      ent_valid;
  logic [DEPTH-1:0]      ent_wb;
  logic [DEPTH-1:0]      ent_load;
  logic [REG_ADDR_W-1:0] ent_dest [DEPTH];
  logic [15:0]           stall_cnt;

  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;
  logic [DEPTH-1:0] ready;
  logic             found1;
  logic             found2;
  logic [IDX_W-1:0] idx1;
  logic [IDX_W-1:0] idx2;
  logic             data_haz;
  logic             hazard;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    match1 = '0;
    match2 = '0;
    ready  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match1[i] = sb.src1_used && sb.id_valid && ent_valid[i] && ent_wb[i] &&
                  (ent_dest[i] == sb.src1_ID) &&
                  !(ZERO_REG_HW && (sb.src1_ID == '0));
      match2[i] = sb.src2_used && sb.id_valid && ent_valid[i] && ent_wb[i] &&
                  (ent_dest[i] == sb.src2_ID) &&
                  !(ZERO_REG_HW && (sb.src2_ID == '0));
      // Branches resolve in ID, so they need their operand one stage later.
      if (sb.is_branch_ID)
        ready[i] = (!ent_load[i] && (i >= 1)) || (i >= LOAD_FWD_IDX + 1);
      else
        ready[i] = !ent_load[i] || (i >= LOAD_FWD_IDX);
    end
  end

  always_comb begin
    found1 = 1'b0;
    found2 = 1'b0;
    idx1   = '0;
    idx2   = '0;
    // Scan oldest to youngest so the youngest match is the one that sticks.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match1[i]) begin
        found1 = 1'b1;
        idx1   = IDX_W'(i);
      end
      if (match2[i]) begin
        found2 = 1'b1;
        idx2   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    if (sb.forward_EN)
      data_haz = (found1 && !ready[idx1]) || (found2 && !ready[idx2]);
    else
      data_haz = (|match1) || (|match2);
    hazard = !rst && (sb.mem_busy || data_haz);
  end

  assign sb.hazard_detected = hazard;
  assign sb.fwd_sel1 = (sb.forward_EN && !hazard && found1) ?
                       SEL_W'(idx1) + SEL_W'(1) : '0;
  assign sb.fwd_sel2 = (sb.forward_EN && !hazard && found2) ?
                       SEL_W'(idx2) + SEL_W'(1) : '0;
  assign sb.stall_count = stall_cnt;

  // Control state: entry valid bits and the stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= '0;
      stall_cnt <= '0;
    end else if (!sb.mem_busy) begin
      ent_valid <= {ent_valid[DEPTH-2:0], sb.id_valid && !hazard && !sb.flush};
      if (hazard)
        stall_cnt <= sat_inc16(stall_cnt);
    end
  end

  // Payload fields: qualified by ent_valid, so they advance without reset.
  always_ff @(posedge clk) begin
    if (!sb.mem_busy) begin
      ent_wb      <= {ent_wb[DEPTH-2:0], sb.wb_en_ID};
      ent_load    <= {ent_load[DEPTH-2:0], sb.mem_r_en_ID};
      ent_dest[0] <= sb.dest_ID;
      for (int i = 1; i < DEPTH; i++)
        ent_dest[i] <= ent_dest[i-1];
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default DEPTH=3 instance for the
// forwarding/stall scenarios, DEPTH=8 instance for counter saturation.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_ADDR_W(4), .DEPTH(3)) sb ();
  hazard_scoreboard_if #(.REG_ADDR_W(4), .DEPTH(8)) sb8 ();

  hazard_scoreboard #(.REG_ADDR_W(4), .DEPTH(3), .LOAD_FWD_IDX(1), .ZERO_REG_HW(1'b1)) dut (
    .clk(clk), .rst(rst), .sb(sb)
  );
  hazard_scoreboard #(.REG_ADDR_W(4), .DEPTH(8), .LOAD_FWD_IDX(1), .ZERO_REG_HW(1'b1)) dut8 (
    .clk(clk), .rst(rst), .sb(sb8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] s1, input logic u1,
                       input logic [3:0] s2, input logic u2, input logic br,
                       input logic [3:0] d, input logic wb, input logic ld,
                       input logic fl, input logic mb);
    sb.id_valid     = v;
    sb.src1_ID      = s1;
    sb.src1_used    = u1;
    sb.src2_ID      = s2;
    sb.src2_used    = u2;
    sb.is_branch_ID = br;
    sb.dest_ID      = d;
    sb.wb_en_ID     = wb;
    sb.mem_r_en_ID  = ld;
    sb.flush        = fl;
    sb.mem_busy     = mb;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    chk("rst_haz", sb.hazard_detected, 0);
    chk("rst_cnt", sb.stall_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    sb.forward_EN = 1'b1;
    sb8.forward_EN = 1'b0;
    sb8.id_valid = 0; sb8.src1_ID = 0; sb8.src1_used = 0; sb8.src2_ID = 0;
    sb8.src2_used = 0; sb8.is_branch_ID = 0; sb8.dest_ID = 0; sb8.wb_en_ID = 0;
    sb8.mem_r_en_ID = 0; sb8.flush = 0; sb8.mem_busy = 0;
    idle();
    #2;
    chk("init_haz", sb.hazard_detected, 0);
    chk("init_fwd1", sb.fwd_sel1, 0);
    chk("init_fwd2", sb.fwd_sel2, 0);
    chk("init_cnt", sb.stall_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ALU write r3, then two consecutive readers of r3
    drive(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    chk("alu_issue_haz", sb.hazard_detected, 0);
    tick();
    drive(1, 3, 1, 0, 0, 0, 7, 1, 0, 0, 0);
    chk("alu_fwd_ex_haz", sb.hazard_detected, 0);
    chk("alu_fwd_ex_sel1", sb.fwd_sel1, 1);
    tick();
    drive(1, 3, 1, 0, 0, 0, 8, 1, 0, 0, 0);
    chk("alu_fwd_mem_sel1", sb.fwd_sel1, 2);
    drain();

    // Load-use on src2
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    tick();
    drive(1, 0, 0, 5, 1, 0, 9, 1, 0, 0, 0);
    chk("ld_use_haz", sb.hazard_detected, 1);
    chk("ld_use_sel2_stall", sb.fwd_sel2, 0);
    tick();
    chk("ld_use_haz_after", sb.hazard_detected, 0);
    chk("ld_use_sel2", sb.fwd_sel2, 2);
    chk("ld_use_cnt", sb.stall_count, 1);
    drain();

    // Youngest match governs: load r3 younger than ALU r3
    drive(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    tick();
    drive(1, 3, 1, 0, 0, 0, 6, 1, 0, 0, 0);
    chk("youngest_haz", sb.hazard_detected, 1);
    tick();
    chk("youngest_haz_after", sb.hazard_detected, 0);
    chk("youngest_sel1", sb.fwd_sel1, 2);
    drain();

    // Forwarding disabled: stall until the writer drops off
    sb.forward_EN = 1'b0;
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    tick();
    drive(1, 2, 1, 0, 0, 0, 10, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("nofwd_haz%0d", k), sb.hazard_detected, 1);
      tick();
    end
    chk("nofwd_clear", sb.hazard_detected, 0);
    chk("nofwd_sel1", sb.fwd_sel1, 0);
    chk("nofwd_cnt", sb.stall_count, 3);
    drain();
    sb.forward_EN = 1'b1;

    // Flush without hazard inserts a bubble
    drive(1, 0, 0, 0, 0, 0, 6, 1, 0, 1, 0);
    chk("flush_haz", sb.hazard_detected, 0);
    tick();
    drive(1, 6, 1, 0, 0, 0, 12, 1, 0, 0, 0);
    chk("flush_bubble_sel1", sb.fwd_sel1, 0);
    chk("flush_bubble_haz", sb.hazard_detected, 0);
    drain();

    // Flush together with a hazard still reports the hazard
    drive(1, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    tick();
    drive(1, 5, 1, 0, 0, 0, 11, 1, 0, 1, 0);
    chk("flush_and_haz", sb.hazard_detected, 1);
    tick();
    drive(1, 11, 1, 0, 0, 0, 13, 1, 0, 0, 0);
    chk("flush_and_haz_bubble", sb.fwd_sel1, 0);
    drain();

    // Branch consumer after ALU and after load
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    tick();
    drive(1, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("br_alu_haz", sb.hazard_detected, 1);
    tick();
    chk("br_alu_clear", sb.hazard_detected, 0);
    chk("br_alu_sel1", sb.fwd_sel1, 2);
    drain();
    drive(1, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0);
    tick();
    drive(1, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("br_ld_haz0", sb.hazard_detected, 1);
    tick();
    chk("br_ld_haz1", sb.hazard_detected, 1);
    tick();
    chk("br_ld_clear", sb.hazard_detected, 0);
    chk("br_ld_sel1", sb.fwd_sel1, 3);
    chk("br_cnt", sb.stall_count, 3);
    drain();

    // Register 0 is hardwired
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    drive(1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0);
    chk("r0_haz", sb.hazard_detected, 0);
    chk("r0_sel1", sb.fwd_sel1, 0);
    chk("r0_sel2", sb.fwd_sel2, 0);
    drain();

    // mem_busy freezes entries and does not count
    drive(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    tick();
    drive(1, 3, 1, 0, 0, 0, 14, 1, 0, 0, 1);
    chk("busy_sel1", sb.fwd_sel1, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("busy_haz%0d", k), sb.hazard_detected, 1);
      tick();
    end
    drive(1, 3, 1, 0, 0, 0, 14, 1, 0, 0, 0);
    chk("busy_release_haz", sb.hazard_detected, 0);
    chk("busy_frozen_sel1", sb.fwd_sel1, 1);
    chk("busy_cnt", sb.stall_count, 3);
    drain();

    // Asynchronous reset in the middle of a load-use stall
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    tick();
    drive(1, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("mid_haz0", sb.hazard_detected, 1);
    tick();
    chk("mid_haz1", sb.hazard_detected, 1);
    chk("mid_cnt", sb.stall_count, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_haz", sb.hazard_detected, 0);
    chk("async_rst_cnt", sb.stall_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_haz", sb.hazard_detected, 0);
    chk("post_rst_sel1", sb.fwd_sel1, 0);
    idle();

    // Saturation: DEPTH=8 self-dependent instruction stalls 8 of every 9 cycles
    do_reset();
    sb8.id_valid = 1; sb8.src1_ID = 1; sb8.src1_used = 1;
    sb8.dest_ID = 1; sb8.wb_en_ID = 1;
    repeat (900) tick();
    chk("sat_partial_cnt", sb8.stall_count, 800);
    repeat (73737 - 900) tick();
    chk("sat_cnt", sb8.stall_count, 16'hFFFF);
    chk("sat_issue_haz", sb8.hazard_detected, 0);
    repeat (9) tick();
    chk("sat_hold_cnt", sb8.stall_count, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 4: register-address width.
REQ-002 SHALL have parameter DEPTH, default 3: in-flight stages tracked after ID (entry 0 = EX ... entry DEPTH-1 = oldest); legal range 2..8.
REQ-003 SHALL have parameter LOAD_FWD_IDX, default 1: first entry index at which load data is forwardable.
REQ-004 SHALL have parameter ZERO_REG_HW, default 1: when 1, register 0 never causes a hazard or forward.
REQ-005 SHALL have one clock; reset is asynchronous and active-high (ports clk, rst below).
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 forward_EN  input  1  1 = forwarding enabled, 0 = stall on every RAW match.
REQ-009 id_valid  input  1  ID holds a real instruction.
REQ-010 src1_ID, src2_ID  input  REG_ADDR_W each  ID source registers.
REQ-011 src1_used, src2_used  input  1 each  source actually read.
REQ-012 is_branch_ID  input  1  ID instruction resolves a branch in ID.
REQ-013 dest_ID  input  REG_ADDR_W  ID destination register.
REQ-014 wb_en_ID, mem_r_en_ID  input  1 each  ID writes back / is a load.
REQ-015 mem_busy  input  1  memory wait; whole pipeline frozen.
REQ-016 flush  input  1  kill ID instruction (taken branch).
REQ-017 hazard_detected  output  1  stall ID/IF this cycle.
REQ-018 fwd_sel1, fwd_sel2  output  $clog2(DEPTH+1) each  0 = register file, k = entry k-1.
REQ-019 stall_count  output  16  saturating count of hazard-stall cycles.

Function
REQ-020 SHALL keep DEPTH entries {valid, dest, wb_en, is_load}; all state in flops, outputs combinational from state and inputs.
REQ-021 Source s SHALL match entry i iff s_used, id_valid, entry valid, entry wb_en, dest equal, and not (ZERO_REG_HW and s==0).
REQ-022 Entry i is "ready" for a non-branch consumer iff !is_load or i >= LOAD_FWD_IDX; for a branch consumer iff (!is_load and i >= 1) or i >= LOAD_FWD_IDX+1.
REQ-023 forward_EN=0: hazard_detected SHALL be 1 iff any source matches any entry; fwd_sel SHALL be 0.
REQ-024 forward_EN=1: per source, the youngest (lowest-index) matching entry governs; hazard_detected=1 iff that entry is not ready for any used source.
REQ-025 fwd_sel SHALL equal youngest matching index+1 when forward_EN=1 and no hazard, else 0.
REQ-026 mem_busy=1 SHALL force hazard_detected=1 and hold all entries unchanged.
REQ-027 mem_busy=0: entry[i] <= entry[i-1] for i>=1 every cycle (stalls never freeze downstream).
REQ-028 mem_busy=0: entry[0] <= {1, dest_ID, wb_en_ID, mem_r_en_ID} iff id_valid and !hazard_detected and !flush; otherwise bubble (valid=0).
REQ-029 flush and hazard simultaneous: bubble inserted; hazard_detected still reported.
REQ-030 stall_count SHALL increment by 1 on each edge with mem_busy=0 and hazard_detected=1, saturating at 16'hFFFF; mem_busy cycles not counted.
REQ-031 Oldest entry SHALL drop off after DEPTH advancing cycles; no wrap-around reuse.

Reset
REQ-032 rst=1 SHALL immediately clear all entries to invalid and stall_count to 0, regardless of clk, including mid-stall or mid-mem_busy.
REQ-033 While rst=1 and after it, hazard_detected SHALL be 0 and fwd_sel 0 until a matching entry is issued.

Verification
REQ-034 forward_EN=1, ALU write r3 issued, next cycle ID reads r3 -> no stall, fwd_sel1=1; following cycle -> fwd_sel1=2.
REQ-035 forward_EN=1, load r5 issued, next ID reads r5 via src2 -> hazard_detected=1 one cycle, bubble inserted, then fwd_sel2=2, stall_count=1.
REQ-036 forward_EN=0, ALU write r2, ID reads r2 -> hazard_detected=1 for DEPTH (3) cycles, then 0 with fwd_sel1=0.
REQ-037 Branch in ID reading r4 right after ALU write r4 -> 1 stall cycle; after load r4 -> 2 stall cycles (LOAD_FWD_IDX=1).
REQ-038 Write r0 then read r0 with ZERO_REG_HW=1 -> no stall, fwd_sel1=0; mem_busy=1 for 4 cycles -> hazard_detected=1, entries frozen, stall_count unchanged.
REQ-039 Assert rst during a load-use stall -> hazard_detected=0, stall_count=0 immediately; saturation check: 65537 forced stalls -> stall_count=16'hFFFF.
